calculation_unit_div_sqrt: RTL and testbench

CALCULATION_UNIT_DIV_SQRT -- requirements
Module: calculation_unit_div_sqrt

---
 rtl/calc2_pkg.sv | 19 +
 rtl/calculation_unit_div_sqrt_step.sv | 38 +++
 rtl/calculation_unit_div_sqrt.sv | 115 +++++++++++
 tb/tb_calculation_unit_div_sqrt.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// Shared types and widths for the radix-2 restoring divide / square-root unit.
package calc2;

  localparam int QR_WIDTH       = 26;
  localparam int DIV_REM_WIDTH  = 26;
  localparam int SQRT_REM_WIDTH = 28;
  localparam int OPND_WIDTH     = 24;
  localparam int RAD_WIDTH      = 25;
  localparam int CNT_WIDTH      = 5;

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(QR_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    DONE
  } state_t;

endpackage

// File: rtl/calculation_unit_div_sqrt_step.sv
// One restoring iteration: compare/subtract for divide or digit-by-digit square root.
module calculation_unit_div_sqrt_step
  import calc2::*;
(
  input  logic                      op_sqrt_i,
  input  logic [DIV_REM_WIDTH-1:0]  rem_i,
  input  logic [OPND_WIDTH-1:0]     divisor_i,
  input  logic [QR_WIDTH-1:0]       root_i,
  input  logic [1:0]                rad_pair_i,
  output logic                      bit_o,
  output logic [SQRT_REM_WIDTH-1:0] rem_o
);

  logic [DIV_REM_WIDTH-1:0]  div_ext;
  logic [DIV_REM_WIDTH-1:0]  div_diff;
  logic [DIV_REM_WIDTH-1:0]  div_kept;
  logic                      div_ge;
  logic [SQRT_REM_WIDTH-1:0] sq_rem;
  logic [SQRT_REM_WIDTH-1:0] sq_trial;
  logic [SQRT_REM_WIDTH-1:0] sq_diff;
  logic                      sq_ge;

  assign div_ext  = DIV_REM_WIDTH'(divisor_i);
  assign div_ge   = rem_i >= div_ext;
  assign div_diff = rem_i - div_ext;
  assign div_kept = div_ge ? div_diff : rem_i;

  // The partial root is right-aligned, so the trial divisor is simply (root<<2)|1.
  assign sq_rem   = {rem_i, rad_pair_i};
  assign sq_trial = {root_i, 2'b01};
  assign sq_ge    = sq_rem >= sq_trial;
  assign sq_diff  = sq_rem - sq_trial;

  assign bit_o = op_sqrt_i ? sq_ge : div_ge;
  assign rem_o = op_sqrt_i ? (sq_ge ? sq_diff : sq_rem)
                           : SQRT_REM_WIDTH'({div_kept, 1'b0});

endmodule

// File: rtl/calculation_unit_div_sqrt.sv
// Iterative divide / square-root unit, one result bit per cycle (26 bits, [1.25]).
// Optional early exit on zero remainder: define DIV_SQRT_EARLY_TERMINATE_EN.
module calculation_unit_div_sqrt
  import calc2::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op_sqrt,
  input  logic [OPND_WIDTH-1:0] dividend,
  input  logic [OPND_WIDTH-1:0] divisor,
  input  logic [RAD_WIDTH-1:0]  radicand,
  input  logic                  flush,
  output logic                  busy,
  output logic                  valid,
  output logic [QR_WIDTH-1:0]   quotient_root,
  output logic                  sticky
);

  state_t                    state_q;
  logic                      op_q;
  logic [OPND_WIDTH-1:0]     divisor_q;
  logic [RAD_WIDTH-1:0]      rad_q;
  logic [SQRT_REM_WIDTH-1:0] rem_q;
  logic [QR_WIDTH-1:0]       result_q;
  logic [CNT_WIDTH-1:0]      count_q;
  logic                      valid_q;
  logic                      sticky_q;

  logic                      step_bit;
  logic [SQRT_REM_WIDTH-1:0] step_rem;
  logic [QR_WIDTH-1:0]       result_d;

  calculation_unit_div_sqrt_step u_step (
    .op_sqrt_i  (op_q),
    .rem_i      (rem_q[DIV_REM_WIDTH-1:0]),
    .divisor_i  (divisor_q),
    .root_i     (result_q),
    .rad_pair_i (rad_q[RAD_WIDTH-1 -: 2]),
    .bit_o      (step_bit),
    .rem_o      (step_rem)
  );

  assign result_d = {result_q[QR_WIDTH-2:0], step_bit};

`ifdef DIV_SQRT_EARLY_TERMINATE_EN
  logic                 early_done;
  logic [CNT_WIDTH-1:0] pad_bits;
  // For sqrt the unconsumed radicand bits are part of the remainder too.
  assign early_done = (step_rem == '0) && (!op_q || (rad_q[RAD_WIDTH-3:0] == '0));
  assign pad_bits   = LAST_STEP - count_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      divisor_q <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q   <= ITERATE;
              op_q      <= op_sqrt;
              divisor_q <= divisor;
              rad_q     <= radicand;
              rem_q     <= op_sqrt ? '0 : SQRT_REM_WIDTH'(dividend);
              result_q  <= '0;
              count_q   <= '0;
            end
          end
          ITERATE: begin
            rem_q   <= step_rem;
            rad_q   <= {rad_q[RAD_WIDTH-3:0], 2'b00};
            count_q <= count_q + 1'b1;
`ifdef DIV_SQRT_EARLY_TERMINATE_EN
            if (early_done) begin
              result_q <= result_d << pad_bits;
              state_q  <= DONE;
            end else
`endif
            begin
              result_q <= result_d;
              if (count_q == LAST_STEP) begin
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            valid_q  <= 1'b1;
            sticky_q <= (rem_q != '0);
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign valid         = valid_q;
  assign quotient_root = result_q;
  assign sticky        = sticky_q;

endmodule

// File: tb/tb_calculation_unit_div_sqrt.sv
// Bench for calculation_unit_div_sqrt: exact-arithmetic reference model, directed and random ops.
module tb_calculation_unit_div_sqrt;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op_sqrt;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic [24:0] radicand;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [25:0] quotient_root;
  logic        sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calculation_unit_div_sqrt dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .op_sqrt       (op_sqrt),
    .dividend      (dividend),
    .divisor       (divisor),
    .radicand      (radicand),
    .flush         (flush),
    .busy          (busy),
    .valid         (valid),
    .quotient_root (quotient_root),
    .sticky        (sticky)
  );

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 27;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

`ifdef DIV_SQRT_EARLY_TERMINATE_EN
  function automatic int tz(input logic [25:0] q);
    for (int i = 0; i < 26; i++) if (q[i]) return i;
    return 26;
  endfunction
`endif

  // Quotient = floor(a*2^25/b); root = floor(sqrt(r*2^27)); sticky = inexact.
  function automatic void model(input logic op, input logic [23:0] a, input logic [23:0] b,
                                input logic [24:0] r, output logic [25:0] q,
                                output logic s, output int lat);
    longint unsigned n, res;
    if (!op) begin
      n   = 64'(a) << 25;
      res = n / 64'(b);
      s   = (n % 64'(b)) != 0;
    end else begin
      n   = 64'(r) << 27;
      res = isqrt(n);
      s   = (res * res) != n;
    end
    q   = res[25:0];
    lat = 27;
`ifdef DIV_SQRT_EARLY_TERMINATE_EN
    if (!s) lat = 26 - tz(q) + 1;
`endif
  endfunction

  task automatic run_op(input logic op, input logic [23:0] a, input logic [23:0] b,
                        input logic [24:0] r, input string tag);
    logic [25:0] eq;
    logic        es;
    int          elat;
    int          lat;
    model(op, a, b, r, eq, es, elat);
    @(negedge clk);
    start = 1'b1; op_sqrt = op; dividend = a; divisor = b; radicand = r;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %0b exp 1", tag, busy);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", tag, lat, elat);
    end
    checks++;
    if (quotient_root !== eq) begin
      errors++;
      $display("FAIL %s quotient_root got %h exp %h", tag, quotient_root, eq);
    end
    checks++;
    if (sticky !== es) begin
      errors++;
      $display("FAIL %s sticky got %0b exp %0b", tag, sticky, es);
    end
    $display("op %s sqrt=%0b a=%h b=%h r=%h q=%h sticky=%0b lat=%0d", tag, op, a, b, r,
             quotient_root, sticky, lat);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; op_sqrt = 1'b0; flush = 1'b0;
    dividend = '0; divisor = 24'h800000; radicand = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, quotient_root, sticky} !== 29'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%0b valid=%0b q=%h sticky=%0b exp all 0",
               busy, valid, quotient_root, sticky);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release got busy=%0b valid=%0b exp 0 0", busy, valid);
    end
  endtask

  task automatic test_directed();
    run_op(1'b0, 24'h800000, 24'h800000, 25'h0, "div_1_1");
    run_op(1'b0, 24'h800000, 24'hC00000, 25'h0, "div_1_1p5");
    run_op(1'b1, 24'h0,      24'h800000, 25'h1200000, "sqrt_2p25");
    run_op(1'b1, 24'h0,      24'h800000, 25'h0800000, "sqrt_1");
    run_op(1'b0, 24'hFFFFFF, 24'h800000, 25'h0, "div_max_min");
    run_op(1'b0, 24'h800000, 24'hFFFFFF, 25'h0, "div_min_max");
    run_op(1'b1, 24'h0,      24'h800000, 25'h1FFFFFF, "sqrt_max");
  endtask

  task automatic test_random_div();
    logic [31:0] ra, rb;
    logic [23:0] a, b;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom();
      rb = $urandom();
      a  = {1'b1, ra[22:0]};
      b  = {1'b1, rb[22:0]};
      if (i % 4 == 1) b = 24'h800000;
      if (i % 4 == 2) b = {1'b1, rb[22:16], 16'h0};
      run_op(1'b0, a, b, 25'(rb), "rand_div");
    end
  endtask

  task automatic test_random_sqrt();
    logic [24:0] r;
    int          k;
    for (int i = 0; i < 16; i++) begin
      r = 25'($urandom_range(32'h0800000, 32'h1FFFFFF));
      if (i % 4 == 1) begin
        k = int'($urandom_range(2048, 4095));
        r = 25'(2 * k * k);
      end
      run_op(1'b1, 24'($urandom()), 24'h800000, r, "rand_sqrt");
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] qa, qb;
    logic        sa, sb;
    int          la, lb;
    int          nvalid;
    int          t1, t2;
    model(1'b0, 24'h800000, 24'hC00000, 25'h0, qa, sa, la);
    model(1'b0, 24'h800000, 24'h800000, 25'h0, qb, sb, lb);
    @(negedge clk);
    start = 1'b1; op_sqrt = 1'b0; dividend = 24'h800000; divisor = 24'hC00000;
    @(negedge clk);
    start = 1'b0; dividend = 24'h800000; divisor = 24'h800000;
    nvalid = 0; t1 = -1; t2 = -1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        nvalid++;
        if (t1 < 0) begin
          t1 = n;
          checks++;
          if (quotient_root !== qa || sticky !== sa) begin
            errors++;
            $display("FAIL b2b_first_result got q=%h s=%0b exp q=%h s=%0b",
                     quotient_root, sticky, qa, sa);
          end
        end else if (t2 < 0) begin
          t2 = n;
          checks++;
          if (quotient_root !== qb || sticky !== sb) begin
            errors++;
            $display("FAIL b2b_second_result got q=%h s=%0b exp q=%h s=%0b",
                     quotient_root, sticky, qb, sb);
          end
        end
      end
      // n=5: mid-operation; n=26: DONE cycle; n=27: first IDLE cycle, accepted.
      start = (n == 5 || n == 26 || n == 27);
    end
    start = 1'b0;
    checks++;
    if (t1 != la) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d exp %0d", t1, la);
    end
    checks++;
    if (t2 != la + lb + 1) begin
      errors++;
      $display("FAIL b2b_second_time got %0d exp %0d", t2, la + lb + 1);
    end
    checks++;
    if (nvalid != 2) begin
      errors++;
      $display("FAIL b2b_valid_cycles got %0d exp 2", nvalid);
    end
    checks++;
    if (busy !== 1'b0 || quotient_root !== qb || sticky !== sb) begin
      errors++;
      $display("FAIL b2b_hold got busy=%0b q=%h s=%0b exp busy=0 q=%h s=%0b",
               busy, quotient_root, sticky, qb, sb);
    end
    $display("op b2b first_at=%0d second_at=%0d valids=%0d", t1, t2, nvalid);
  endtask

  task automatic test_flush();
    int nvalid;
    @(negedge clk);
    start = 1'b1; op_sqrt = 1'b0; dividend = 24'h800000; divisor = 24'hC00000;
    @(negedge clk);
    start = 1'b0;
    nvalid = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
      if (n == 11) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL flush_busy got %0b exp 0", busy);
        end
      end
      flush = (n == 10);
    end
    flush = 1'b0;
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL flush_no_valid got %0d valids exp 0", nvalid);
    end
    $display("op flush valids=%0d", nvalid);
    run_op(1'b1, 24'h0, 24'h800000, 25'h1200000, "after_flush");

    @(negedge clk);
    start = 1'b1; flush = 1'b1; op_sqrt = 1'b0;
    dividend = 24'h800000; divisor = 24'h800000;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_busy got %0b exp 0", busy);
    end
    nvalid = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL flush_start_no_valid got %0d valids exp 0", nvalid);
    end
    $display("op flush_with_start valids=%0d", nvalid);
  endtask

  task automatic test_reset_midop();
    int nvalid;
    int nbusy;
    @(negedge clk);
    start = 1'b1; op_sqrt = 1'b0; dividend = 24'h800000; divisor = 24'hC00000;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, quotient_root, sticky} !== 29'd0) begin
      errors++;
      $display("FAIL reset_midop got busy=%0b valid=%0b q=%h sticky=%0b exp all 0",
               busy, valid, quotient_root, sticky);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    nvalid = 0; nbusy = 0;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
      if (busy === 1'b1) nbusy++;
    end
    checks++;
    if (nvalid != 0 || nbusy != 0) begin
      errors++;
      $display("FAIL reset_midop_after got valids=%0d busy_cycles=%0d exp 0 0", nvalid, nbusy);
    end
    $display("op reset_midop valids=%0d busy_cycles=%0d", nvalid, nbusy);
    run_op(1'b0, 24'h800000, 24'hC00000, 25'h0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_div();
    test_random_sqrt();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
